// File: rtl/p_status_reg.sv
// Processor status register: six stored flags (N,V,D,I,Z,C) with per-bit
// priority resolution, stack push/pull formatting, branch test and IRQ mask.

module p_flag_cell (
  input  logic clk,
  input  logic rst,
  input  logic pull_en,
  input  logic pull_val,
  input  logic frc_en,
  input  logic frc_val,
  input  logic op_en,
  input  logic op_val,
  input  logic upd_en,
  input  logic upd_val,
  input  logic rst_val,
  output logic d,
  output logic q
);
  // d is exported so same-edge consumers can see the value being loaded
  always_comb begin
    d = q;
    if (rst)          d = rst_val;
    else if (pull_en) d = pull_val;
    else if (frc_en)  d = frc_val;
    else if (op_en)   d = op_val;
    else if (upd_en)  d = upd_val;
  end

  always_ff @(posedge clk) q <= d;
endmodule

module p_status_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] alu_status,
  input  logic       upd_nz,
  input  logic       upd_c,
  input  logic       upd_v,
  input  logic [2:0] flag_op,
  input  logic       pull_load,
  input  logic [7:0] pull_data,
  input  logic       int_entry,
  input  logic       brk_flag,
  input  logic       sync,
  input  logic [1:0] br_sel,
  input  logic       br_val,
  output logic [7:0] p_out,
  output logic [7:0] p_push,
  output logic       br_taken,
  output logic       irq_inhibit,
  output logic       carry_out
);
  localparam int NUM_FLAGS = 6;
  localparam int FC = 0, FZ = 1, FI = 2, FD = 3, FV = 4, FN = 5;

  localparam logic [2:0] OP_CLC = 3'd1, OP_SEC = 3'd2, OP_CLI = 3'd3,
                         OP_SEI = 3'd4, OP_CLV = 3'd5, OP_CLD = 3'd6,
                         OP_SED = 3'd7;

  logic [NUM_FLAGS-1:0] pull_v, frc_en, frc_val, op_en, op_val;
  logic [NUM_FLAGS-1:0] upd_en, upd_val, rst_v, flag_d, flag_q;
  logic                 unused_bits;

  // Status byte and ALU flag word share bit positions for N,V,D,I,Z,C
  assign pull_v  = {pull_data[7:6], pull_data[3:0]};
  assign rst_v   = NUM_FLAGS'(1) << FI;
  assign frc_en  = NUM_FLAGS'(int_entry) << FI;
  assign frc_val = NUM_FLAGS'(1) << FI;

  assign upd_en  = {upd_nz, upd_v, 1'b0, 1'b0, upd_nz, upd_c};
  assign upd_val = {alu_status[7:6], 1'b0, 1'b0, alu_status[1:0]};

  always_comb begin
    op_en  = '0;
    op_val = '0;
    unique case (flag_op)
      OP_CLC:  begin op_en[FC] = 1'b1; op_val[FC] = 1'b0; end
      OP_SEC:  begin op_en[FC] = 1'b1; op_val[FC] = 1'b1; end
      OP_CLI:  begin op_en[FI] = 1'b1; op_val[FI] = 1'b0; end
      OP_SEI:  begin op_en[FI] = 1'b1; op_val[FI] = 1'b1; end
      OP_CLV:  begin op_en[FV] = 1'b1; op_val[FV] = 1'b0; end
      OP_CLD:  begin op_en[FD] = 1'b1; op_val[FD] = 1'b0; end
      OP_SED:  begin op_en[FD] = 1'b1; op_val[FD] = 1'b1; end
      default: ;
    endcase
  end

  for (genvar g = 0; g < NUM_FLAGS; g++) begin : g_flag
    p_flag_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .pull_en (pull_load),
      .pull_val(pull_v[g]),
      .frc_en  (frc_en[g]),
      .frc_val (frc_val[g]),
      .op_en   (op_en[g]),
      .op_val  (op_val[g]),
      .upd_en  (upd_en[g]),
      .upd_val (upd_val[g]),
      .rst_val (rst_v[g]),
      .d       (flag_d[g]),
      .q       (flag_q[g])
    );
  end

  // Mask follows I only at instruction boundaries, except on interrupt entry
  always_ff @(posedge clk) begin
    if (rst)            irq_inhibit <= 1'b1;
    else if (int_entry) irq_inhibit <= flag_d[FI];
    else if (sync)      irq_inhibit <= flag_q[FI];
  end

  assign p_out     = {flag_q[FN], flag_q[FV], 1'b1, 1'b0,     flag_q[FD], flag_q[FI], flag_q[FZ], flag_q[FC]};
  assign p_push    = {flag_q[FN], flag_q[FV], 1'b1, brk_flag, flag_q[FD], flag_q[FI], flag_q[FZ], flag_q[FC]};
  assign carry_out = flag_q[FC];

  always_comb begin
    unique case (br_sel)
      2'd0:    br_taken = (flag_q[FN] == br_val);
      2'd1:    br_taken = (flag_q[FV] == br_val);
      2'd2:    br_taken = (flag_q[FC] == br_val);
      default: br_taken = (flag_q[FZ] == br_val);
    endcase
  end

  assign unused_bits = ^{alu_status[5:2], pull_data[5:4]};
endmodule

// File: tb/tb_p_status_reg.sv
// Directed-vector bench for p_status_reg with hand-computed expected values.

module tb_p_status_reg;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] alu_status;
  logic       upd_nz, upd_c, upd_v;
  logic [2:0] flag_op;
  logic       pull_load;
  logic [7:0] pull_data;
  logic       int_entry, brk_flag, sync;
  logic [1:0] br_sel;
  logic       br_val;
  logic [7:0] p_out, p_push;
  logic       br_taken, irq_inhibit, carry_out;

  int checks = 0;
  int errors = 0;

  p_status_reg dut (
    .clk(clk), .rst(rst), .alu_status(alu_status), .upd_nz(upd_nz),
    .upd_c(upd_c), .upd_v(upd_v), .flag_op(flag_op), .pull_load(pull_load),
    .pull_data(pull_data), .int_entry(int_entry), .brk_flag(brk_flag),
    .sync(sync), .br_sel(br_sel), .br_val(br_val), .p_out(p_out),
    .p_push(p_push), .br_taken(br_taken), .irq_inhibit(irq_inhibit),
    .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst = 0; alu_status = 8'h00; upd_nz = 0; upd_c = 0; upd_v = 0;
    flag_op = 3'd0; pull_load = 0; pull_data = 8'h00; int_entry = 0;
    sync = 0;
  endtask

  // inputs change 1ns after the edge, outputs are sampled there too
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    brk_flag = 0; br_sel = 2'd2; br_val = 1'b1;
    #2;

    // reset with conflicting inputs present
    rst = 1; pull_load = 1; pull_data = 8'hFF; int_entry = 1; flag_op = 3'd7;
    step();
    step();
    chk("reset_p_out", p_out, 8'h24);
    chk("reset_irq", {7'b0, irq_inhibit}, 8'h01);
    chk("reset_br_taken", {7'b0, br_taken}, 8'h00);
    chk("reset_carry", {7'b0, carry_out}, 8'h00);

    // ALU update of N,Z,C
    alu_status = 8'h83; upd_nz = 1; upd_c = 1;
    step();
    chk("alu_p_out", p_out, 8'hA7);
    brk_flag = 1;
    #1 chk("alu_p_push", p_push, 8'hB7);
    brk_flag = 0;
    chk("alu_carry", {7'b0, carry_out}, 8'h01);

    // bits 5..2 of alu_status ignored
    alu_status = 8'h7C; upd_nz = 1; upd_c = 1; upd_v = 1;
    step();
    chk("alu_ignore_bits", p_out, 8'h64);

    // CLI then sync: mask lags by one instruction
    flag_op = 3'd3;
    step();
    chk("cli_p_out", p_out, 8'h60);
    chk("cli_irq_before_sync", {7'b0, irq_inhibit}, 8'h01);
    sync = 1;
    step();
    chk("cli_irq_after_sync", {7'b0, irq_inhibit}, 8'h00);

    // interrupt entry masks immediately
    int_entry = 1;
    step();
    chk("int_p_out", p_out, 8'h64);
    chk("int_irq", {7'b0, irq_inhibit}, 8'h01);

    // CLI with sync in same cycle: mask captures old I
    flag_op = 3'd3; sync = 1;
    step();
    chk("race_p_out", p_out, 8'h60);
    chk("race_irq", {7'b0, irq_inhibit}, 8'h01);
    sync = 1;
    step();
    chk("race_irq_next_sync", {7'b0, irq_inhibit}, 8'h00);

    // pull overrides CLC and int_entry
    pull_load = 1; pull_data = 8'hFF; flag_op = 3'd1; int_entry = 1;
    step();
    chk("pull_priority", p_out, 8'hEF);
    chk("pull_irq", {7'b0, irq_inhibit}, 8'h01);

    // flag_op vs upd_* per bit
    pull_load = 1; pull_data = 8'h00;
    step();
    chk("pull_zero", p_out, 8'h20);
    alu_status = 8'h82; upd_nz = 1; upd_c = 1; flag_op = 3'd2;
    step();
    chk("sec_with_upd", p_out, 8'hA3);
    alu_status = 8'h01; upd_c = 1; flag_op = 3'd1;
    step();
    chk("clc_with_upd_c", p_out, 8'hA2);
    flag_op = 3'd7;
    step();
    chk("sed", p_out, 8'hAA);
    alu_status = 8'h40; upd_v = 1;
    step();
    chk("upd_v", p_out, 8'hEA);
    alu_status = 8'h40; upd_v = 1; flag_op = 3'd5;
    step();
    chk("clv_with_upd_v", p_out, 8'hAA);
    flag_op = 3'd6;
    step();
    chk("cld", p_out, 8'hA2);
    flag_op = 3'd4;
    step();
    chk("sei", p_out, 8'hA6);
    // int_entry beats CLI on I while other flags still follow flag_op/upd
    int_entry = 1; flag_op = 3'd3; alu_status = 8'h00; upd_nz = 1;
    step();
    chk("int_vs_cli", p_out, 8'h24);

    // reset wins over everything mid-stream
    pull_load = 1; pull_data = 8'hFF;
    step();
    rst = 1; pull_load = 1; pull_data = 8'hFF; flag_op = 3'd3; int_entry = 1;
    step();
    chk("rst_priority", p_out, 8'h24);
    chk("rst_priority_irq", {7'b0, irq_inhibit}, 8'h01);

    // branch condition for every select, flag value and required value
    for (int s = 0; s < 4; s++) begin
      for (int f = 0; f < 2; f++) begin
        logic [7:0] pd;
        pd = 8'h00;
        case (s)
          0: pd[7] = f[0];
          1: pd[6] = f[0];
          2: pd[0] = f[0];
          default: pd[1] = f[0];
        endcase
        pull_load = 1; pull_data = pd;
        step();
        for (int v = 0; v < 2; v++) begin
          br_sel = s[1:0]; br_val = v[0];
          #1 chk($sformatf("br_sel%0d_f%0d_v%0d", s, f, v),
                 {7'b0, br_taken}, {7'b0, (f == v)});
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
